// File: rtl/sprite_rom_arbiter_if.sv
// Bus bundle between the sprite ROM arbiter, its two requesters and the ROM.
// The arbiter uses the slave modport; the requesters/ROM side uses master.
interface sprite_rom_arbiter_if #(
  parameter int unsigned RAM_WIDTH     = 8,
  parameter int unsigned RAM_ADDR_BITS = 14
);
  // Video pixel-fetch requester
  logic                     vid_req;
  logic [RAM_ADDR_BITS-1:0] vid_addr;
  logic                     vid_gnt;
  logic                     vid_valid;
  logic [RAM_WIDTH-1:0]     vid_data;
  // Game-logic requester
  logic                     cpu_req;
  logic [RAM_ADDR_BITS-1:0] cpu_addr;
  logic                     cpu_gnt;
  logic                     cpu_valid;
  logic [RAM_WIDTH-1:0]     cpu_data;
  // ROM port
  logic                     rom_en;
  logic [RAM_ADDR_BITS-1:0] rom_addr;
  logic [RAM_WIDTH-1:0]     rom_data;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_addr, rom_data,
    output vid_gnt, vid_valid, vid_data, cpu_gnt, cpu_valid, cpu_data, rom_en, rom_addr
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_addr, rom_data,
    input  vid_gnt, vid_valid, vid_data, cpu_gnt, cpu_valid, cpu_data, rom_en, rom_addr
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Two-port arbiter for a single registered-read sprite ROM. Video has fixed
// priority; the logic requester is aged and, once forced through, keeps the
// ROM for a bounded burst so it cannot starve during active video.
module sprite_rom_arbiter #(
  parameter int unsigned RAM_WIDTH     = 8,
  parameter int unsigned RAM_ADDR_BITS = 14,
  parameter int unsigned MAX_WAIT      = 8,
  parameter int unsigned CPU_BURST     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sprite_rom_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {StPriVid, StPriCpu} state_e;

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [7:0] burst_q, burst_d;
  logic       owner_q, owner_d;      // 0: video, 1: logic
  logic       rd_pend_q, rd_pend_d;  // a ROM read was issued last cycle
  logic       vid_gnt, cpu_gnt, rom_en;

  // Grant decision and priority state transitions
  always_comb begin
    vid_gnt = 1'b0;
    cpu_gnt = 1'b0;
    state_d = state_q;
    burst_d = burst_q;
    case (state_q)
      StPriVid: begin
        if (bus.cpu_req && (wait_q == 8'(MAX_WAIT))) begin
          cpu_gnt = 1'b1;
          burst_d = 8'd1;
          state_d = StPriCpu;
        end else if (bus.vid_req) begin
          vid_gnt = 1'b1;
        end else if (bus.cpu_req) begin
          cpu_gnt = 1'b1;
        end
      end
      StPriCpu: begin
        if (bus.cpu_req && (burst_q < 8'(CPU_BURST))) begin
          cpu_gnt = 1'b1;
          burst_d = burst_q + 8'd1;
        end else begin
          vid_gnt = bus.vid_req;
          burst_d = 8'd0;
          state_d = StPriVid;
        end
      end
      default: state_d = StPriVid;
    endcase
    // No grant may escape while the block is held in reset
    if (!rst_n) begin
      vid_gnt = 1'b0;
      cpu_gnt = 1'b0;
    end
  end

  // Aging counter and return-path bookkeeping
  always_comb begin
    wait_d = wait_q;
    if (cpu_gnt || !bus.cpu_req) begin
      wait_d = 8'd0;
    end else if (wait_q != 8'hff) begin
      wait_d = wait_q + 8'd1;
    end
    rom_en    = vid_gnt | cpu_gnt;
    owner_d   = rom_en ? cpu_gnt : owner_q;
    rd_pend_d = rom_en;
  end

  // State registers; reset drops any in-flight read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StPriVid;
      wait_q    <= 8'd0;
      burst_q   <= 8'd0;
      owner_q   <= 1'b0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      burst_q   <= burst_d;
      owner_q   <= owner_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign bus.vid_gnt   = vid_gnt;
  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.rom_en    = rom_en;
  assign bus.rom_addr  = cpu_gnt ? bus.cpu_addr : bus.vid_addr;
  // Valid follows the previous cycle's grant; owner tells whose read it was
  assign bus.vid_valid = rd_pend_q & ~owner_q;
  assign bus.cpu_valid = rd_pend_q & owner_q;
  assign bus.vid_data  = bus.rom_data;
  assign bus.cpu_data  = bus.rom_data;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a registered-read ROM model.
module tb_sprite_rom_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  sprite_rom_arbiter_if #(.RAM_WIDTH(8), .RAM_ADDR_BITS(14)) bus ();

  sprite_rom_arbiter #(
    .RAM_WIDTH    (8),
    .RAM_ADDR_BITS(14),
    .MAX_WAIT     (8),
    .CPU_BURST    (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_fn(input logic [13:0] a);
    return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h5a;
  endfunction

  // ROM model: one-cycle registered read
  always @(posedge clk) begin
    if (bus.rom_en) bus.rom_data <= rom_fn(bus.rom_addr);
  end

  // Pending requests must keep their address until granted
  assert property (@(posedge clk) disable iff (!rst_n)
    (bus.cpu_req && !bus.cpu_gnt) ##1 bus.cpu_req |-> $stable(bus.cpu_addr))
    else $error("FAIL cpu_addr_hold");
  assert property (@(posedge clk) disable iff (!rst_n)
    (bus.vid_req && !bus.vid_gnt) ##1 bus.vid_req |-> $stable(bus.vid_addr))
    else $error("FAIL vid_addr_hold");

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Video always requests; cpu_req and expected cpu grants given per cycle as bit masks
  task automatic run_seq(input string tag, input int ncyc, input logic [31:0] creq,
                         input logic [31:0] exp_c);
    int          vcnt = 0;
    int          ccnt = 0;
    logic        prev_v = 1'b0;
    logic        prev_c = 1'b0;
    logic [13:0] prev_a = '0;
    logic [13:0] va, ca;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      va           = 14'(32'h0200 + vcnt);
      ca           = 14'(32'h3000 + ccnt);
      bus.vid_req  = 1'b1;
      bus.vid_addr = va;
      bus.cpu_req  = creq[c];
      bus.cpu_addr = ca;
      #1;
      check_eq($sformatf("%s cpu_gnt c%0d", tag, c), 32'(bus.cpu_gnt), 32'(exp_c[c]));
      check_eq($sformatf("%s vid_gnt c%0d", tag, c), 32'(bus.vid_gnt), 32'(!exp_c[c]));
      check_eq($sformatf("%s rom_addr c%0d", tag, c), 32'(bus.rom_addr),
               32'(exp_c[c] ? ca : va));
      if (c > 0) begin
        check_eq($sformatf("%s vid_valid c%0d", tag, c), 32'(bus.vid_valid), 32'(prev_v));
        check_eq($sformatf("%s cpu_valid c%0d", tag, c), 32'(bus.cpu_valid), 32'(prev_c));
        check_eq($sformatf("%s data c%0d", tag, c),
                 32'(prev_c ? bus.cpu_data : bus.vid_data), 32'(rom_fn(prev_a)));
      end
      prev_c = exp_c[c];
      prev_v = !exp_c[c];
      prev_a = exp_c[c] ? ca : va;
      if (exp_c[c]) ccnt++;
      else vcnt++;
    end
    @(negedge clk);
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.vid_req  = 1'b1;
    bus.cpu_req  = 1'b1;
    bus.vid_addr = 14'h0011;
    bus.cpu_addr = 14'h0022;

    // Reset held with both requests high
    @(negedge clk);
    #1;
    check_eq("rst rom_en", 32'(bus.rom_en), 32'd0);
    check_eq("rst vid_gnt", 32'(bus.vid_gnt), 32'd0);
    check_eq("rst cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
    check_eq("rst vid_valid", 32'(bus.vid_valid), 32'd0);
    check_eq("rst cpu_valid", 32'(bus.cpu_valid), 32'd0);
    @(negedge clk);
    #1;
    check_eq("rst vid_valid 2", 32'(bus.vid_valid), 32'd0);
    check_eq("rst cpu_valid 2", 32'(bus.cpu_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rel vid_gnt", 32'(bus.vid_gnt), 32'd1);
    check_eq("rel cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
    check_eq("rel rom_en", 32'(bus.rom_en), 32'd1);
    @(negedge clk);
    bus.vid_req = 1'b0;
    bus.cpu_req = 1'b0;
    #1;
    check_eq("rel vid_valid", 32'(bus.vid_valid), 32'd1);
    check_eq("rel vid_data", 32'(bus.vid_data), 32'(rom_fn(14'h0011)));

    // Single logic read
    do_reset();
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 14'h0123;
    #1;
    check_eq("single cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    check_eq("single rom_addr", 32'(bus.rom_addr), 32'h0123);
    check_eq("single rom_en", 32'(bus.rom_en), 32'd1);
    @(negedge clk);
    bus.cpu_req = 1'b0;
    #1;
    check_eq("single cpu_valid", 32'(bus.cpu_valid), 32'd1);
    check_eq("single vid_valid", 32'(bus.vid_valid), 32'd0);
    check_eq("single cpu_data", 32'(bus.cpu_data), 32'h78);

    // Contention: cpu wins 8..11 and 20
    do_reset();
    run_seq("contend", 21, 32'h001f_ffff, 32'h0010_0f00);

    // Burst cut short at cycle 10; aging restarts from 11, forced grant at 19
    do_reset();
    run_seq("cut", 20, 32'h000f_fbff, 32'h0008_0300);

    // Aging reset: one low cycle at 5, forced grant 8 contended cycles later
    do_reset();
    run_seq("aging", 15, 32'h0000_7fdf, 32'h0000_4000);

    // Reset right after a video grant discards the read
    do_reset();
    @(negedge clk);
    bus.vid_req  = 1'b1;
    bus.vid_addr = 14'h0042;
    #1;
    check_eq("midrst vid_gnt", 32'(bus.vid_gnt), 32'd1);
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    bus.vid_req = 1'b0;
    #1;
    check_eq("midrst vid_valid a", 32'(bus.vid_valid), 32'd0);
    @(negedge clk);
    #1;
    check_eq("midrst vid_valid b", 32'(bus.vid_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("midrst vid_valid c", 32'(bus.vid_valid), 32'd0);
    @(negedge clk);
    #1;
    check_eq("midrst vid_valid d", 32'(bus.vid_valid), 32'd0);
    check_eq("midrst cpu_valid d", 32'(bus.cpu_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
